// File: rtl/dragonfang_pkg.sv
// Shared dragonfang lane types: operand/write-back bundles, bit_mode encodings,
// operand_fetch FSM states and the SEW helper.
package dragonfang_pkg;

    localparam int CHUNK_BITS = 64;
    localparam int TAG_W      = 8;

    typedef enum logic [2:0] {
        BIT_MODE_8  = 3'd0,
        BIT_MODE_16 = 3'd1,
        BIT_MODE_32 = 3'd2,
        BIT_MODE_64 = 3'd3
    } bit_mode_t;

    typedef struct packed {
        bit_mode_t bit_mode;
        logic      vm;
        logic      vma;
        logic      vta;
    } write_back_vector_t;

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [CHUNK_BITS-1:0] data;
    } data_packet_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_VS2  = 3'd1,
        RD_VS1  = 3'd2,
        RD_VD   = 3'd3,
        RD_V0   = 3'd4,
        CAPTURE = 3'd5,
        OUT     = 3'd6,
        FINISH  = 3'd7
    } operand_fetch_state_t;

    // Encodings outside the four defined modes behave as 64-bit elements.
    function automatic int unsigned sew_bits(input bit_mode_t bit_mode);
        case (bit_mode)
            BIT_MODE_8:  return 8;
            BIT_MODE_16: return 16;
            BIT_MODE_32: return 32;
            default:     return 64;
        endcase
    endfunction

endpackage

// File: rtl/operand_fetch_chunk_counter.sv
// Chunk bookkeeping for operand_fetch: derives the chunk count of a request
// (vl clamped to VLMAX) and walks chunk_idx, flagging the final chunk.
module chunk_counter
    import dragonfang_pkg::*;
#(
    parameter  int VLEN   = 512,
    localparam int CHUNKS = VLEN / CHUNK_BITS,
    localparam int VL_W   = $clog2(VLEN / 8) + 1,
    localparam int IDX_W  = $clog2(CHUNKS),
    localparam int N_W    = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [VL_W-1:0]  vl,
    input  bit_mode_t        bit_mode,
    output logic             zero,
    output logic [IDX_W-1:0] chunk_idx,
    output logic             last
);

    logic [N_W-1:0] n_chunks;
    logic [N_W-1:0] n_next;
    int unsigned    sew;
    int unsigned    vlmax;
    int unsigned    eff_vl;
    int unsigned    n_calc;

    always_comb begin
        sew    = sew_bits(bit_mode);
        vlmax  = VLEN / sew;
        eff_vl = (32'(vl) < vlmax) ? 32'(vl) : vlmax;
        n_calc = (eff_vl * sew + CHUNK_BITS - 1) / CHUNK_BITS;
        n_next = n_calc[N_W-1:0];
        zero   = (n_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_chunks  <= '0;
            chunk_idx <= '0;
        end else if (load) begin
            n_chunks  <= n_next;
            chunk_idx <= '0;
        end else if (advance) begin
            chunk_idx <= chunk_idx + 1'b1;
        end
    end

    assign last = ({1'b0, chunk_idx} == (n_chunks - 1'b1));

endmodule

// File: rtl/operand_fetch.sv
// Sequential vs2/vs1/vd/v0 reader for one vector instruction, one 64-bit chunk per bundle.
// Optional: DRAGONFANG_OPERAND_FETCH_MASK_SKIP_EN skips the v0 read for unmasked (vm=1) ops.
module operand_fetch
    import dragonfang_pkg::*;
#(
    parameter  int VLEN   = 512,
    localparam int CHUNKS = VLEN / CHUNK_BITS,
    localparam int VL_W   = $clog2(VLEN / 8) + 1,
    localparam int IDX_W  = $clog2(CHUNKS),
    localparam int ADDR_W = 5 + IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4:0]           req_vs1,
    input  logic [4:0]           req_vs2,
    input  logic [4:0]           req_vd,
    input  logic [VL_W-1:0]      req_vl,
    input  write_back_vector_t   req_write_back_vector,
    output logic                 rf_rd_en,
    output logic [ADDR_W-1:0]    rf_rd_addr,
    input  logic [63:0]          rf_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output data_packet_t         vs1_packet,
    output data_packet_t         vs2_packet,
    output data_packet_t         vd_old_packet,
    output data_packet_t         v0_packet,
    output write_back_vector_t   out_write_back_vector,
    output logic                 done,
    output operand_fetch_state_t fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and the bundle is frozen while valid waits for ready.

    operand_fetch_state_t state_q, state_d;
    logic [4:0]           vs1_q, vs2_q, vd_q;
    logic [IDX_W-1:0]     chunk_idx;
    logic                 last, zero, skip_v0;
    logic                 accept, advance;
    data_packet_t         cap_pkt;

    assign accept  = (state_q == IDLE) && req_valid;
    assign advance = (state_q == OUT) && out_ready && !last;

`ifdef DRAGONFANG_OPERAND_FETCH_MASK_SKIP_EN
    assign skip_v0 = out_write_back_vector.vm;
`else
    assign skip_v0 = 1'b0;
`endif

    chunk_counter #(.VLEN(VLEN)) u_chunk_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .advance   (advance),
        .vl        (req_vl),
        .bit_mode  (req_write_back_vector.bit_mode),
        .zero      (zero),
        .chunk_idx (chunk_idx),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        rf_rd_en   = 1'b0;
        rf_rd_addr = '0;
        case (state_q)
            IDLE:    if (req_valid) state_d = zero ? FINISH : RD_VS2;
            RD_VS2: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = {vs2_q, chunk_idx};
                state_d    = RD_VS1;
            end
            RD_VS1: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = {vs1_q, chunk_idx};
                state_d    = RD_VD;
            end
            RD_VD: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = {vd_q, chunk_idx};
                state_d    = skip_v0 ? CAPTURE : RD_V0;
            end
            RD_V0: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = {5'd0, chunk_idx};
                state_d    = CAPTURE;
            end
            CAPTURE: state_d = OUT;
            OUT:     if (out_ready) state_d = last ? FINISH : RD_VS2;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign done      = (state_q == FINISH);
    assign fsm_state = state_q;

    always_comb begin
        cap_pkt.tag  = {{(TAG_W - IDX_W){1'b0}}, chunk_idx};
        cap_pkt.data = rf_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs1_q                 <= '0;
            vs2_q                 <= '0;
            vd_q                  <= '0;
            out_write_back_vector <= '0;
        end else if (accept) begin
            vs1_q                 <= req_vs1;
            vs2_q                 <= req_vs2;
            vd_q                  <= req_vd;
            out_write_back_vector <= req_write_back_vector;
        end
    end

    // Read data lags the issue by one cycle, so each state captures the previous read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs2_packet    <= '0;
            vs1_packet    <= '0;
            vd_old_packet <= '0;
            v0_packet     <= '0;
        end else begin
            case (state_q)
                RD_VS1: vs2_packet    <= cap_pkt;
                RD_VD:  vs1_packet    <= cap_pkt;
                RD_V0:  vd_old_packet <= cap_pkt;
                CAPTURE: begin
                    if (skip_v0) begin
                        vd_old_packet  <= cap_pkt;
                        v0_packet.tag  <= cap_pkt.tag;
                        v0_packet.data <= '1;
                    end else begin
                        v0_packet <= cap_pkt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and random operand_fetch scenarios checked against a chunk-level reference model.
module tb_operand_fetch;
  import dragonfang_pkg::*;

  localparam int VLEN   = 512;
  localparam int VL_W   = 7;
  localparam int ADDR_W = 8;

  logic clk, rst_n;
  logic req_valid, req_ready;
  logic [4:0] req_vs1, req_vs2, req_vd;
  logic [VL_W-1:0] req_vl;
  write_back_vector_t req_write_back_vector, out_write_back_vector;
  logic rf_rd_en;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [63:0] rf_rd_data;
  logic out_valid, out_ready, done;
  data_packet_t vs1_packet, vs2_packet, vd_old_packet, v0_packet;
  operand_fetch_state_t fsm_state;

  operand_fetch #(.VLEN(VLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vd(req_vd), .req_vl(req_vl),
    .req_write_back_vector(req_write_back_vector),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .vs1_packet(vs1_packet), .vs2_packet(vs2_packet),
    .vd_old_packet(vd_old_packet), .v0_packet(v0_packet),
    .out_write_back_vector(out_write_back_vector),
    .done(done), .fsm_state(fsm_state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---- register file model and read-address monitor ----
  logic [63:0] rf_mem [0:255];
  logic [63:0] rf_data_q;
  logic [ADDR_W-1:0] addr_log[$];
  logic [ADDR_W-1:0] exp_q[$];
  int done_count = 0;

  assign rf_rd_data = rf_data_q;

  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_data_q <= rf_mem[rf_rd_addr];
      addr_log.push_back(rf_rd_addr);
    end
    if (done) done_count++;
  end

  // ---- scoreboard ----
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] got_vs2 [0:7];
  logic [63:0] got_v0  [0:7];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Chunk count straight from the vl/SEW rules.
  function automatic int model_chunks(input int vl, input logic [2:0] mode);
    int sew, vlmax, eff;
    sew   = (mode < 3'd4) ? (8 << mode) : 64;
    vlmax = VLEN / sew;
    eff   = (vl < vlmax) ? vl : vlmax;
    return (eff * sew + 63) / 64;
  endfunction

  function automatic logic [ADDR_W-1:0] rf_addr(input logic [4:0] r, input int c);
    logic [2:0] cc;
    cc = 3'(c);
    return {r, cc};
  endfunction

  task automatic run_instr(input logic [4:0] vs2, input logic [4:0] vs1, input logic [4:0] vd,
                           input int vl, input logic [2:0] mode, input logic vm,
                           input int stall_chunk, input int stall_cycles);
    int n, waited, dc0, exp_lat;
    logic skip;
    write_back_vector_t wbv;
    logic [287:0] snap;
    logic [63:0] exp_v0;
    wbv.bit_mode = bit_mode_t'(mode);
    wbv.vm  = vm;
    wbv.vma = 1'($urandom_range(0, 1));
    wbv.vta = 1'($urandom_range(0, 1));
    n = model_chunks(vl, mode);
`ifdef DRAGONFANG_OPERAND_FETCH_MASK_SKIP_EN
    skip = vm;
`else
    skip = 1'b0;
`endif
    exp_lat = skip ? 4 : 5;
    check("req_ready_idle", 512'(req_ready), 512'(1));
    req_vs2 = vs2; req_vs1 = vs1; req_vd = vd; req_vl = 7'(vl);
    req_write_back_vector = wbv;
    req_valid = 1'b1;
    dc0 = done_count;
    addr_log.delete();
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write_back_vector = '0;
    check("wbv_latched", 512'(out_write_back_vector), 512'(wbv));
    if (n == 0) begin
      check("zero_no_reads", 512'(addr_log.size()), 512'(0));
    end
    for (int c = 0; c < n; c++) begin
      waited = 0;
      while (!out_valid && waited < 50) begin
        @(posedge clk); #1;
        waited++;
      end
      check("chunk_latency", 512'(waited), 512'(exp_lat));
      if (c == stall_chunk) begin
        out_ready = 1'b0;
        snap = {vs2_packet, vs1_packet, vd_old_packet, v0_packet};
        repeat (stall_cycles) begin
          @(posedge clk); #1;
          check("stall_packets", 512'({vs2_packet, vs1_packet, vd_old_packet, v0_packet}), 512'(snap));
          check("stall_valid", 512'({out_valid, rf_rd_en}), 512'(2'b10));
        end
        out_ready = 1'b1;
      end
      exp_q.delete();
      exp_q.push_back(rf_addr(vs2, c));
      exp_q.push_back(rf_addr(vs1, c));
      exp_q.push_back(rf_addr(vd, c));
      if (!skip) exp_q.push_back(rf_addr(5'd0, c));
      check("read_count", 512'(addr_log.size()), 512'(exp_q.size()));
      while (exp_q.size() > 0 && addr_log.size() > 0)
        check("read_addr", 512'(addr_log.pop_front()), 512'(exp_q.pop_front()));
      addr_log.delete();
      exp_v0 = skip ? 64'hFFFF_FFFF_FFFF_FFFF : rf_mem[rf_addr(5'd0, c)];
      check("vs2_packet", 512'(vs2_packet), 512'({8'(c), rf_mem[rf_addr(vs2, c)]}));
      check("vs1_packet", 512'(vs1_packet), 512'({8'(c), rf_mem[rf_addr(vs1, c)]}));
      check("vd_old_packet", 512'(vd_old_packet), 512'({8'(c), rf_mem[rf_addr(vd, c)]}));
      check("v0_packet", 512'(v0_packet), 512'({8'(c), exp_v0}));
      check("out_wbv", 512'(out_write_back_vector), 512'(wbv));
      if (c < 8) begin
        got_vs2[c] = vs2_packet.data;
        got_v0[c]  = v0_packet.data;
      end
      @(posedge clk); #1;
    end
    check("done_pulse", 512'({done, req_ready}), 512'(2'b10));
    @(posedge clk); #1;
    check("done_after", 512'({done, req_ready}), 512'(2'b01));
    check("done_count", 512'(done_count - dc0), 512'(1));
    check("no_stray_reads", 512'(addr_log.size()), 512'(0));
  endtask

  // ---- directed + random sequence ----
  initial begin
    int dc0, waited;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_vs1 = '0; req_vs2 = '0; req_vd = '0; req_vl = '0;
    req_write_back_vector = '0;
    out_ready = 1'b1;
    rf_data_q = '0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 8; c++)
        rf_mem[r * 8 + c] = {32'(r), 32'(c)};

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 512'({out_valid, done, rf_rd_en, rf_rd_addr, req_ready}), 512'(1));
    check("reset_packets", 512'({vs2_packet, vs1_packet, vd_old_packet, v0_packet}), 512'(0));
    check("reset_wbv", 512'(out_write_back_vector), 512'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 64-bit, vl=8: eight chunks over the {reg,chunk} pattern
    run_instr(5'd3, 5'd5, 5'd7, 8, 3'd3, 1'b0, -1, 0);
    check("pattern_vs2_c2", 512'(got_vs2[2]), 512'(64'h0000_0003_0000_0002));
    check("pattern_v0_c2", 512'(got_v0[2]), 512'(64'h0000_0000_0000_0002));

    // 8-bit, vl=17 -> three chunks
    run_instr(5'd9, 5'd10, 5'd11, 17, 3'd0, 1'b0, -1, 0);
    // vl=0 -> immediate done
    run_instr(5'd1, 5'd2, 5'd4, 0, 3'd2, 1'b0, -1, 0);
    // stall 10 cycles on chunk 1 of a 16-bit, vl=20 (5 chunks) op
    run_instr(5'd12, 5'd13, 5'd14, 20, 3'd1, 1'b0, 1, 10);
    // vl beyond VLMAX, and an undefined bit_mode treated as 64-bit
    run_instr(5'd6, 5'd8, 5'd15, 100, 3'd3, 1'b1, -1, 0);
    run_instr(5'd16, 5'd17, 5'd18, 3, 3'd5, 1'b1, -1, 0);

    // reset while in RD_VD
    dc0 = done_count;
    req_vs2 = 5'd3; req_vs1 = 5'd5; req_vd = 5'd7; req_vl = 7'd8;
    req_write_back_vector = '{bit_mode: BIT_MODE_64, vm: 1'b0, vma: 1'b1, vta: 1'b1};
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waited = 0;
    while (fsm_state != RD_VD && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("reach_rd_vd", 512'(fsm_state), 512'(RD_VD));
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", 512'({out_valid, done, rf_rd_en, rf_rd_addr}), 512'(0));
    check("midreset_packets", 512'({vs2_packet, vs1_packet, vd_old_packet, v0_packet}), 512'(0));
    check("midreset_wbv", 512'(out_write_back_vector), 512'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_ready", 512'(req_ready), 512'(1));
    repeat (8) @(posedge clk);
    #1;
    check("midreset_no_done", 512'(done_count - dc0), 512'(0));

    // random registers, modes, vl and mask policy over random RF contents
    for (int a = 0; a < 256; a++)
      rf_mem[a] = {$urandom, $urandom};
    for (int t = 0; t < 14; t++) begin
      run_instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                $urandom_range(0, 127), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                (t % 4 == 0) ? 0 : -1, $urandom_range(1, 6));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
